// File: rtl/mips_hazard_unit.sv
// mips_hazard_unit
//   Hazard-detection and forwarding controller for the pipelined MIPS core.
//   Keeps a registered scoreboard of in-flight destinations for post-ID
//   stages 1 (EX) .. N_STAGES (WB). It drives forwarding selects, load-use
//   stalls and redirect flushes.
//
// Parameters
//   N_STAGES          tracked post-ID stages (>= 2)
//   REG_ADDR_W        register index width
//   LOAD_READY_STAGE  first stage whose load result can be forwarded
//   REDIRECT_STAGE    stage in which taken branches/jumps resolve
//   SEL_W             forward-select width (derived, do not override)
//
// Ports
//   clk, reset (async, active-low)
//   id_*_i            decoded ID-stage instruction
//   redirect_i        instruction in REDIRECT_STAGE changes PC this cycle
//   stall_o, flush_o  pipeline control
//   fwd_a_sel_o/fwd_b_sel_o  0 = register file, k = result of stage k
//   stall_count_o/flush_count_o  saturating counters, present only when
//                     HAZARD_STATS_EN is defined
module mips_hazard_unit #(
  parameter int unsigned N_STAGES         = 3,
  parameter int unsigned REG_ADDR_W       = 5,
  parameter int unsigned LOAD_READY_STAGE = 2,
  parameter int unsigned REDIRECT_STAGE   = 2,
  parameter int unsigned SEL_W            = $clog2(N_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rs_i,
  input  logic                  id_uses_rt_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_mem_read_i,
  input  logic                  redirect_i,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic [SEL_W-1:0]      fwd_a_sel_o,
  output logic [SEL_W-1:0]      fwd_b_sel_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]           stall_count_o,
  output logic [15:0]           flush_count_o
`endif
);

  logic [N_STAGES:1]     sb_valid;
  logic [N_STAGES:1]     sb_load;
  logic [REG_ADDR_W-1:0] sb_rd [1:N_STAGES];

  logic a_found, b_found;
  logic a_early_load, b_early_load;

  // Scan from youngest (stage 1) to oldest; the first hit wins.
  always_comb begin
    fwd_a_sel_o  = '0;
    fwd_b_sel_o  = '0;
    a_found      = 1'b0;
    b_found      = 1'b0;
    a_early_load = 1'b0;
    b_early_load = 1'b0;
    for (int unsigned k = 1; k <= N_STAGES; k++) begin
      if (!a_found && id_uses_rs_i && (id_rs_i != '0) &&
          sb_valid[k] && (sb_rd[k] == id_rs_i)) begin
        a_found      = 1'b1;
        fwd_a_sel_o  = SEL_W'(k);
        a_early_load = sb_load[k] && (k < LOAD_READY_STAGE);
      end
      if (!b_found && id_uses_rt_i && (id_rt_i != '0) &&
          sb_valid[k] && (sb_rd[k] == id_rt_i)) begin
        b_found      = 1'b1;
        fwd_b_sel_o  = SEL_W'(k);
        b_early_load = sb_load[k] && (k < LOAD_READY_STAGE);
      end
    end
  end

  // Redirect overrides any load-use stall.
  assign stall_o = id_valid_i && !redirect_i && (a_early_load || b_early_load);
  assign flush_o = redirect_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_valid <= '0;
      sb_load  <= '0;
      for (int unsigned k = 1; k <= N_STAGES; k++) sb_rd[k] <= '0;
    end else begin
      // Stages up to REDIRECT_STAGE hold wrong-path work on a redirect;
      // the redirecting instruction itself shifts out of REDIRECT_STAGE.
      for (int unsigned k = 2; k <= N_STAGES; k++) begin
        if (redirect_i && (k <= REDIRECT_STAGE)) begin
          sb_valid[k] <= 1'b0;
          sb_load[k]  <= 1'b0;
          sb_rd[k]    <= '0;
        end else begin
          sb_valid[k] <= sb_valid[k-1];
          sb_load[k]  <= sb_load[k-1];
          sb_rd[k]    <= sb_rd[k-1];
        end
      end
      if (redirect_i || stall_o) begin
        sb_valid[1] <= 1'b0;
        sb_load[1]  <= 1'b0;
        sb_rd[1]    <= '0;
      end else begin
        sb_valid[1] <= id_valid_i && id_reg_write_i && (id_rd_i != '0);
        sb_load[1]  <= id_mem_read_i;
        sb_rd[1]    <= id_rd_i;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_o <= '0;
      flush_count_o <= '0;
    end else begin
      if (stall_o && (stall_count_o != '1)) stall_count_o <= stall_count_o + 16'd1;
      if (flush_o && (flush_count_o != '1)) flush_count_o <= flush_count_o + 16'd1;
    end
  end
`endif

endmodule
